// File: rtl/const_arbiter.sv
// Round-robin arbiter sharing one const_unit between decode (port 0) and branch/address-gen (port 1),
// with a 2-entry result buffer. Define CONST_ARB_FIXED_PRIO_EN for fixed priority (port 0 wins ties).
module const_arbiter #(
  parameter int IN_W       = 6,
  parameter int OUT_W      = 8,
  parameter int PRIO_RESET = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [IN_W-1:0]  req0_imm,
  input  logic             req0_cs,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [IN_W-1:0]  req1_imm,
  input  logic             req1_cs,
  output logic [IN_W-1:0]  cu_data_in,
  output logic             cu_cs,
  input  logic [OUT_W-1:0] cu_data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_id
);

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } buf_state_t;

  buf_state_t       state_r;
  buf_state_t       state_next_s;
  logic             grant0_s;
  logic             grant1_s;
  logic             not_full_s;
  logic             push_s;
  logic             pop_s;
  logic [OUT_W-1:0] head_data_r;
  logic [OUT_W-1:0] tail_data_r;
  logic             head_id_r;
  logic             tail_id_r;
  logic             out_valid_r;

`ifdef CONST_ARB_FIXED_PRIO_EN
  // Fixed priority: requester 0 always wins.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (req0_valid) begin
      grant0_s = 1'b1;
    end else if (req1_valid) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end
`else
  logic last_grant_r;

  // Round-robin: on a tie the requester that did not win the last accepted push is granted.
  always_comb begin
    grant0_s = 1'b0;
    grant1_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant0_s = last_grant_r;
      grant1_s = ~last_grant_r;
    end else if (req0_valid) begin
      grant0_s = 1'b1;
    end else if (req1_valid) begin
      grant1_s = 1'b1;
    end else begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end
  end

  // Priority rotates only on an accepted push, so a stalled grant keeps its turn.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= (PRIO_RESET == 0) ? 1'b1 : 1'b0;
    end else if (push_s) begin
      last_grant_r <= grant1_s;
    end
  end
`endif

  // Drive the shared const_unit from the granted requester, zero when idle.
  always_comb begin
    cu_data_in = {IN_W{1'b0}};
    cu_cs      = 1'b0;
    if (grant1_s) begin
      cu_data_in = req1_imm;
      cu_cs      = req1_cs;
    end else if (grant0_s) begin
      cu_data_in = req0_imm;
      cu_cs      = req0_cs;
    end else begin
      cu_data_in = {IN_W{1'b0}};
      cu_cs      = 1'b0;
    end
  end

  // Ready depends only on grant and buffer occupancy, never on out_ready.
  assign not_full_s = (state_r != TWO);
  assign req0_ready = grant0_s && not_full_s;
  assign req1_ready = grant1_s && not_full_s;
  assign push_s     = (grant0_s || grant1_s) && not_full_s;
  assign pop_s      = out_valid_r && out_ready;

  // Buffer occupancy next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      EMPTY: begin
        if (push_s) state_next_s = ONE;
        else        state_next_s = EMPTY;
      end
      ONE: begin
        if (push_s && !pop_s)      state_next_s = TWO;
        else if (!push_s && pop_s) state_next_s = EMPTY;
        else                       state_next_s = ONE;
      end
      TWO: begin
        if (pop_s) state_next_s = ONE;
        else       state_next_s = TWO;
      end
      default: state_next_s = EMPTY;
    endcase
  end

  // Occupancy register; out_valid is registered alongside it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= EMPTY;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      out_valid_r <= (state_next_s != EMPTY);
    end
  end

  // Entry storage: head is the output, tail holds the second entry while TWO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data_r <= {OUT_W{1'b0}};
      head_id_r   <= 1'b0;
      tail_data_r <= {OUT_W{1'b0}};
      tail_id_r   <= 1'b0;
    end else begin
      case (state_r)
        EMPTY: begin
          if (push_s) begin
            head_data_r <= cu_data_out;
            head_id_r   <= grant1_s;
          end
        end
        ONE: begin
          if (push_s && pop_s) begin
            head_data_r <= cu_data_out;
            head_id_r   <= grant1_s;
          end else if (push_s) begin
            tail_data_r <= cu_data_out;
            tail_id_r   <= grant1_s;
          end
        end
        TWO: begin
          if (pop_s) begin
            head_data_r <= tail_data_r;
            head_id_r   <= tail_id_r;
          end
        end
        default: begin
          head_data_r <= {OUT_W{1'b0}};
          head_id_r   <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = head_data_r;
  assign out_id    = head_id_r;

endmodule
